// File: rtl/md_sched.sv
// Issue controller and hazard scheduler for the multiply/divide unit.
// Gates E-stage HI/LO ops, tracks the unit's busy window, stalls D-stage md ops, drains after reset.
module md_sched #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] e_op,
   input  logic       e_valid,
   input  logic       e_flush,
   input  logic       d_is_md,
   output logic [3:0] md_op,
   output logic       busy_o,
   output logic       stall_d,
   output logic       rd_hi,
   output logic       done,
   output logic       proto_err
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_RECOVER = 2'd0,
      ST_IDLE    = 2'd1,
      ST_BUSY    = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               perr_q, perr_d;

   logic op_md;
   logic op_long;
   logic op_mul;
   logic go;
   logic cnt_last;

   // Op decode: 1..8 are real md ops, 1..4 occupy the unit for a latency window
   always_comb begin
      op_md    = (e_op >= 4'd1) && (e_op <= 4'd8);
      op_long  = (e_op >= 4'd1) && (e_op <= 4'd4);
      op_mul   = (e_op == 4'd1) || (e_op == 4'd3);
      go       = (state_q == ST_IDLE) && e_valid && !e_flush && op_md;
      cnt_last = (cnt_q == CNT_W'(1));
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;

      case (state_q)
         ST_RECOVER, ST_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_last) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (go && op_long) begin
               state_d = ST_BUSY;
               cnt_d   = op_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            end
         end
         default: begin
            state_d = ST_RECOVER;
            cnt_d   = CNT_W'(DIV_LAT);
         end
      endcase

      // An md op reaching E while the unit is not accepting means upstream ignored a stall
      if (e_valid && op_md && (state_q != ST_IDLE) && !e_flush) perr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RECOVER;
         cnt_q   <= CNT_W'(DIV_LAT);
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      md_op     = go ? e_op : 4'd0;
      busy_o    = (state_q != ST_IDLE);
      done      = (state_q != ST_IDLE) && cnt_last;
      stall_d   = d_is_md && (busy_o || (go && op_long));
      rd_hi     = (e_op == 4'd5);
      proto_err = perr_q;
   end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed steps plus randomized traffic against a
// cycle-count reference model (the unit is free again from a known cycle number).
module tb_md_sched;

   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;

   logic       clk;
   logic       reset_n;
   logic [3:0] e_op;
   logic       e_valid;
   logic       e_flush;
   logic       d_is_md;
   logic [3:0] md_op;
   logic       busy_o;
   logic       stall_d;
   logic       rd_hi;
   logic       done;
   logic       proto_err;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycle index since reset release, first cycle the unit is free
   int  m_cyc;
   int  m_free;
   bit  m_perr;

   md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .e_op      (e_op),
      .e_valid   (e_valid),
      .e_flush   (e_flush),
      .d_is_md   (d_is_md),
      .md_op     (md_op),
      .busy_o    (busy_o),
      .stall_d   (stall_d),
      .rd_hi     (rd_hi),
      .done      (done),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, advance the model at the edge
   task automatic step(input logic [3:0] op, input logic v, input logic fl, input logic dmd);
      bit busy_e, go_e, md_e, long_e;
      e_op = op; e_valid = v; e_flush = fl; d_is_md = dmd;
      #1;
      md_e   = (op >= 4'd1) && (op <= 4'd8);
      long_e = (op >= 4'd1) && (op <= 4'd4);
      busy_e = (m_cyc < m_free);
      go_e   = !busy_e && v && !fl && md_e;
      chk("md_op",     md_op,            go_e ? op : 4'd0);
      chk("busy_o",    {3'd0, busy_o},   {3'd0, busy_e});
      chk("done",      {3'd0, done},     {3'd0, (m_cyc == m_free - 1)});
      chk("stall_d",   {3'd0, stall_d},  {3'd0, dmd && (busy_e || (go_e && long_e))});
      chk("rd_hi",     {3'd0, rd_hi},    {3'd0, (op == 4'd5)});
      chk("proto_err", {3'd0, proto_err}, {3'd0, m_perr});
      @(posedge clk);
      if (go_e && (op == 4'd1 || op == 4'd3)) m_free = m_cyc + 1 + int'(MULT_LAT);
      if (go_e && (op == 4'd2 || op == 4'd4)) m_free = m_cyc + 1 + int'(DIV_LAT);
      if (v && md_e && busy_e && !fl) m_perr = 1'b1;
      m_cyc++;
      @(negedge clk);
   endtask

   // Reset values while reset is held, for both d_is_md polarities
   task automatic check_in_reset();
      e_op = 4'd1; e_valid = 1'b1; e_flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         d_is_md = k[0];
         #1;
         chk("rst_busy",  {3'd0, busy_o},    4'd1);
         chk("rst_md_op", md_op,             4'd0);
         chk("rst_done",  {3'd0, done},      4'd0);
         chk("rst_perr",  {3'd0, proto_err}, 4'd0);
         chk("rst_stall", {3'd0, stall_d},   {3'd0, d_is_md});
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      m_cyc = 0; m_free = int'(DIV_LAT); m_perr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      e_op = 4'd0; e_valid = 1'b0; e_flush = 1'b0; d_is_md = 1'b0;
      m_cyc = 0; m_free = int'(DIV_LAT); m_perr = 1'b0;
      @(negedge clk);
      check_in_reset();
      @(posedge clk);
      release_reset();

      // Post-reset drain, then IDLE
      for (int i = 0; i < 13; i++) step(4'd0, 1'b0, 1'b0, 1'b1);

      // mult: busy t+1..t+5, done in t+5
      step(4'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
      step(4'd5, 1'b1, 1'b0, 1'b0);
      step(4'd6, 1'b1, 1'b0, 1'b0);

      // divu with D-stage md op held: stall t..t+10
      step(4'd4, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) step(4'd0, 1'b0, 1'b0, 1'b1);

      // Flushed div in IDLE: no issue, no stall
      step(4'd2, 1'b1, 1'b1, 1'b1);
      step(4'd0, 1'b0, 1'b0, 1'b1);

      // Back-to-back single-cycle ops
      step(4'd7, 1'b1, 1'b0, 1'b1);
      step(4'd8, 1'b1, 1'b0, 1'b1);
      step(4'd5, 1'b1, 1'b0, 1'b1);
      step(4'd6, 1'b1, 1'b0, 1'b1);

      // Stall violation right after a mult issue latches proto_err
      step(4'd1, 1'b1, 1'b0, 1'b0);
      step(4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(4'd0, 1'b0, 1'b0, 1'b0);

      // Flush during BUSY leaves the window intact
      step(4'd2, 1'b1, 1'b0, 1'b1);
      step(4'd6, 1'b1, 1'b1, 1'b1);
      step(4'd0, 1'b0, 1'b1, 1'b1);

      // Reset in BUSY cycle 3: immediate RECOVER, full drain after release
      step(4'd0, 1'b0, 1'b0, 1'b1);
      reset_n = 1'b0;
      check_in_reset();
      @(posedge clk);
      release_reset();
      for (int i = 0; i < 12; i++) step(4'd0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic, mostly respecting the stall
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         logic v, fl, dmd;
         op  = 4'($urandom_range(0, 15));
         v   = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 7) == 0);
         dmd = 1'($urandom_range(0, 1));
         if (m_cyc < m_free && $urandom_range(0, 19) != 0) v = 1'b0;
         step(op, v, fl, dmd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
